// File: rtl/window_pkg.sv
// Shared constants and helpers for the sliding-window line buffer.
package window_pkg;

  // Default window edge when the parent does not override K.
  localparam int K_DEFAULT = 3;

  // Bits needed to hold a coordinate in 0..n-1 (never narrower than 1).
  function automatic int coord_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Row-major slot index of a window pixel; slot 0 is the top-left pixel.
  function automatic int slot_idx(input int row, input int col, input int k);
    return row * k + col;
  endfunction

endpackage

// File: rtl/line_buffer_ram.sv
// One image row of storage, single address port shared by read and write.
// rd_data shows the contents at addr as they were before this cycle's
// write lands, so a single access both fetches the older row's pixel and
// replaces it with the newer one. Contents are deliberately not reset.
module line_buffer_ram
  import window_pkg::*;
#(
  parameter int DEPTH = 340,
  parameter int WIDTH = 1,
  localparam int ADDR_W = coord_w(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wr_data,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  assign rd_data = mem[addr];

  // Write the new column entry at the end of the cycle.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wr_data;
    end
  end

endmodule

// File: rtl/window_line_buffer.sv
// K x K sliding-window generator over a raster pixel stream.
// K-1 row buffers plus a K x K column shift register; the shift register
// doubles as the window output register, since it only moves on an accept
// and accepts are blocked while a window is stalled.
// Optional build macro WIN_SUM_EN adds the win_sum output (sum of all
// window pixels, registered alongside win_data).
module window_line_buffer
  import window_pkg::*;
#(
  parameter int PIX_W = 1,
  parameter int IMG_W = 340,
  parameter int IMG_H = 440,
  parameter int K     = K_DEFAULT,
  localparam int ROW_W = coord_w(IMG_H),
  localparam int COL_W = coord_w(IMG_W),
  localparam int SUM_W = PIX_W + coord_w(K * K)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [PIX_W-1:0]       in_pix,
  output logic                   win_valid,
  input  logic                   win_ready,
  output logic [K*K*PIX_W-1:0]   win_data,
  output logic [ROW_W-1:0]       win_row,
  output logic [COL_W-1:0]       win_col,
  output logic                   frame_done
`ifdef WIN_SUM_EN
  ,
  output logic [SUM_W-1:0]       win_sum
`endif
);

  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] COL_FIRST = COL_W'(K - 1);
  localparam logic [ROW_W-1:0] ROW_FIRST = ROW_W'(K - 1);

  logic             accept;
  logic             col_last;
  logic             row_last;
  logic             win_hit;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;

  logic [PIX_W-1:0] lb_wdata [K-1];
  logic [PIX_W-1:0] lb_rdata [K-1];
  logic [PIX_W-1:0] col_vec  [K];
  logic [PIX_W-1:0] win_q    [K][K];

  assign in_ready = !win_valid || win_ready;
  assign accept   = in_valid && in_ready;
  assign col_last = (col == COL_LAST);
  assign row_last = (row == ROW_LAST);
  // Rows above K-1 would pull stale line-buffer data; columns below K-1
  // would pull pixels from the previous row or frame.
  assign win_hit  = (row >= ROW_FIRST) && (col >= COL_FIRST);

  // Raster position of the next pixel to be accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Buffer j holds row r-1-j; each one passes its old entry down the chain.
  genvar j;
  generate
    for (j = 0; j < K - 1; j++) begin : g_lb
      if (j == 0) begin : g_head
        assign lb_wdata[j] = in_pix;
      end else begin : g_tail
        assign lb_wdata[j] = lb_rdata[j-1];
      end

      line_buffer_ram #(
        .DEPTH (IMG_W),
        .WIDTH (PIX_W)
      ) u_ram (
        .clk     (clk),
        .we      (accept),
        .addr    (col),
        .wr_data (lb_wdata[j]),
        .rd_data (lb_rdata[j])
      );

      // Oldest row goes to the top of the incoming column.
      assign col_vec[K-2-j] = lb_rdata[j];
    end
  endgenerate

  assign col_vec[K-1] = in_pix;

  // Shift the window one column left and append the incoming column.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else if (accept) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) begin
          win_q[r][c] <= win_q[r][c+1];
        end
        win_q[r][K-1] <= col_vec[r];
      end
    end
  end

  // Flatten the window into row-major slots.
  always_comb begin
    win_data = '0;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        win_data[slot_idx(r, c, K)*PIX_W +: PIX_W] = win_q[r][c];
      end
    end
  end

  // Window handshake, coordinates and end-of-frame pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_valid  <= 1'b0;
      win_row    <= '0;
      win_col    <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= accept && row_last && col_last;
      if (accept && win_hit) begin
        win_valid <= 1'b1;
        win_row   <= row - ROW_FIRST;
        win_col   <= col - COL_FIRST;
      end else if (win_ready) begin
        win_valid <= 1'b0;
      end
    end
  end

`ifdef WIN_SUM_EN
  logic [SUM_W-1:0] sum_next;

  // Sum of the window as it will look after this accept.
  always_comb begin
    sum_next = '0;
    for (int r = 0; r < K; r++) begin
      for (int c = 1; c < K; c++) begin
        sum_next = sum_next + SUM_W'(win_q[r][c]);
      end
      sum_next = sum_next + SUM_W'(col_vec[r]);
    end
  end

  // Register the sum in lockstep with the window contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_sum <= '0;
    end else if (accept) begin
      win_sum <= sum_next;
    end
  end
`else
  // Window data only; no pixel sum is produced in this build.
`endif

endmodule

// File: tb/tb_window_line_buffer.sv
module tb_window_line_buffer;

  localparam int PIX_W = 8;
  localparam int IMG_W = 5;
  localparam int IMG_H = 4;
  localparam int K     = 3;
  localparam int DW    = K * K * PIX_W;
  localparam int NPIX  = IMG_W * IMG_H;
  localparam int SW    = PIX_W + $clog2(K * K);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [PIX_W-1:0] in_pix = '0;
  logic             win_valid;
  logic             win_ready = 1'b1;
  logic [DW-1:0]    win_data;
  logic [1:0]       win_row;
  logic [2:0]       win_col;
  logic             frame_done;
`ifdef WIN_SUM_EN
  logic [SW-1:0]    win_sum;
`endif

  always #5 clk = ~clk;

  window_line_buffer #(
    .PIX_W (PIX_W),
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .K     (K)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pix     (in_pix),
    .win_valid  (win_valid),
    .win_ready  (win_ready),
    .win_data   (win_data),
    .win_row    (win_row),
    .win_col    (win_col),
    .frame_done (frame_done)
`ifdef WIN_SUM_EN
    ,
    .win_sum    (win_sum)
`endif
  );

  typedef struct {
    logic [DW-1:0] data;
    int            row;
    int            col;
    int            sum;
    logic          last;
  } exp_t;

  typedef struct {
    int   pix;
    logic exp_win;
    int   exp_row;
    int   exp_col;
    logic exp_done;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[NPIX];

  int n_checks   = 0;
  int n_fail     = 0;
  int win_count  = 0;
  int done_count = 0;
  int m_row      = 0;
  int m_col      = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Pixel value equals its raster index within the frame.
  function automatic logic [DW-1:0] exp_window(input int r0, input int c0);
    logic [DW-1:0] d;
    d = '0;
    for (int rr = 0; rr < K; rr++)
      for (int cc = 0; cc < K; cc++)
        d[(rr*K+cc)*PIX_W +: PIX_W] = PIX_W'((r0 + rr) * IMG_W + c0 + cc);
    return d;
  endfunction

  function automatic int exp_sum(input int r0, input int c0);
    int s;
    s = 0;
    for (int rr = 0; rr < K; rr++)
      for (int cc = 0; cc < K; cc++)
        s += (r0 + rr) * IMG_W + c0 + cc;
    return s;
  endfunction

  task automatic send(input int val);
    int waited;
    waited = 0;
    in_valid = 1'b1;
    in_pix   = PIX_W'(val);
    @(negedge clk);
    while (!in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: pixel %0d not taken after %0d cycles", val, waited);
      in_valid = 1'b0;
      return;
    end
    if (m_row >= K - 1 && m_col >= K - 1)
      sb.push_back('{exp_window(m_row - K + 1, m_col - K + 1), m_row - K + 1, m_col - K + 1,
                     exp_sum(m_row - K + 1, m_col - K + 1),
                     (m_row == IMG_H - 1 && m_col == IMG_W - 1)});
    if (m_col == IMG_W - 1) begin
      m_col = 0;
      m_row = (m_row == IMG_H - 1) ? 0 : m_row + 1;
    end else begin
      m_col++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    m_row = 0;
    m_col = 0;
    win_count = 0;
    done_count = 0;
    @(negedge clk);
    chk("rst_win_valid", win_valid, 0);
    chk("rst_win_data", win_data, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic finish_frame(input string tag, input int exp_wins, input int exp_dones);
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_win_count"}, win_count, exp_wins);
    chk({tag, "_done_count"}, done_count, exp_dones);
    chk({tag, "_sb_empty"}, sb.size(), 0);
  endtask

  // Scoreboard check whenever a window is handed over.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (frame_done) begin
        done_count++;
        chk("frame_done_with_valid", win_valid, 1);
      end
      if (win_valid && win_ready) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_window: row %0d col %0d", win_row, win_col);
        end else begin
          e = sb.pop_front();
          chk("win_data", win_data, e.data);
          chk("win_row", win_row, e.row);
          chk("win_col", win_col, e.col);
          chk("frame_done_on_last", frame_done, e.last);
`ifdef WIN_SUM_EN
          chk("win_sum", win_sum, e.sum);
`endif
          win_count++;
        end
      end
    end
  end

  initial begin
    logic [DW-1:0] held;

    for (int i = 0; i < NPIX; i++) tbl[i] = '{i, 1'b0, 0, 0, 1'b0};
    tbl[12] = '{12, 1'b1, 0, 0, 1'b0};
    tbl[13] = '{13, 1'b1, 0, 1, 1'b0};
    tbl[14] = '{14, 1'b1, 0, 2, 1'b0};
    tbl[17] = '{17, 1'b1, 1, 0, 1'b0};
    tbl[18] = '{18, 1'b1, 1, 1, 1'b0};
    tbl[19] = '{19, 1'b1, 1, 2, 1'b1};

    reset_dut();

    // Continuous single frame, per-pixel expectations from the table.
    win_ready = 1'b1;
    for (int i = 0; i < NPIX; i++) begin
      send(tbl[i].pix);
      chk($sformatf("t1_win_valid_p%0d", i), win_valid, tbl[i].exp_win);
      chk($sformatf("t1_frame_done_p%0d", i), frame_done, tbl[i].exp_done);
      if (tbl[i].exp_win) begin
        chk($sformatf("t1_row_p%0d", i), win_row, tbl[i].exp_row);
        chk($sformatf("t1_col_p%0d", i), win_col, tbl[i].exp_col);
      end
    end
`ifdef WIN_SUM_EN
    chk("t1_last_sum", win_sum, 117);
`endif
    finish_frame("t1", 6, 1);

    // Consumer stall for three cycles on the first window.
    reset_dut();
    for (int i = 0; i < 12; i++) send(i);
    win_ready = 1'b0;
    send(12);
`ifdef WIN_SUM_EN
    chk("t2_first_sum", win_sum, 54);
`endif
    held = win_data;
    chk("t2_first_window", held, exp_window(0, 0));
    in_valid = 1'b1;
    in_pix   = PIX_W'(13);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t2_stall_in_ready", in_ready, 0);
      chk("t2_stall_valid", win_valid, 1);
      chk("t2_stall_data", win_data, held);
      chk("t2_stall_col", win_col, 0);
      @(posedge clk);
      #1;
    end
    win_ready = 1'b1;
    for (int i = 13; i < NPIX; i++) send(i);
    finish_frame("t2", 6, 1);

    // Reset in the middle of a frame, then a clean frame.
    reset_dut();
    for (int i = 0; i < 9; i++) send(i);
    reset_dut();
    for (int i = 0; i < NPIX; i++) send(i);
    finish_frame("t3", 6, 1);

    // Two frames back to back.
    reset_dut();
    for (int i = 0; i < 2 * NPIX; i++) send(i % NPIX);
    finish_frame("t4", 12, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
